// File: rtl/apb_reg_slave_pkg.sv
// Shared types and sizes for the APB register slave and its decoder.
package apb_reg_slave_pkg;
  localparam int unsigned XLEN       = 64;
  localparam int unsigned PADDR_SIZE = 32;
  localparam int unsigned APB_WAIT_W = 4;

  typedef enum logic {APB_IDLE, APB_ACCESS} ApbSlvState;
endpackage

// File: rtl/apb_io.sv
// APB4 link bundle: the requester drives address/control/data, the completer drives the response.
interface ApbIO #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 64
);
  logic [ADDR_WIDTH-1:0]   paddr;
  logic                    psel;
  logic                    penable;
  logic                    pwrite;
  logic [2:0]              pprot;
  logic [DATA_WIDTH-1:0]   pwdata;
  logic [DATA_WIDTH/8-1:0] pstrb;
  logic [DATA_WIDTH-1:0]   prdata;
  logic                    pready;
  logic                    pslverr;

  modport master (output paddr, psel, penable, pwrite, pprot, pwdata, pstrb,
                  input  prdata, pready, pslverr);
  modport slave  (input  paddr, psel, penable, pwrite, pprot, pwdata, pstrb,
                  output prdata, pready, pslverr);
endinterface

// File: rtl/apb_reg_slave_decode.sv
// Combinational address decode: register index plus the illegal-access flag.
module apb_slave_decode
  import apb_reg_slave_pkg::*;
#(
  parameter int unsigned            REG_NUM    = 8,
  parameter logic [PADDR_SIZE-1:0]  BASE_ADDR  = '0,
  parameter logic [REG_NUM-1:0]     RO_MASK    = '0,
  parameter bit                     PRIV_WRITE = 1'b1
)(
  input  logic [PADDR_SIZE-1:0]      paddr_i,
  input  logic                       pwrite_i,
  input  logic [2:0]                 pprot_i,
  output logic [$clog2(REG_NUM)-1:0] idx_o,
  output logic                       err_o
);
  localparam int unsigned           IDX_W  = $clog2(REG_NUM);
  localparam int unsigned           BYTE_W = $clog2(XLEN/8);
  localparam logic [PADDR_SIZE-1:0] SPAN   = PADDR_SIZE'(REG_NUM*XLEN/8);

  logic [PADDR_SIZE-1:0] off;
  logic                  unused_prot;

  // Addresses below BASE_ADDR wrap to huge offsets and land in the range error.
  assign off         = paddr_i - BASE_ADDR;
  assign idx_o       = off[IDX_W+BYTE_W-1:BYTE_W];
  assign unused_prot = ^pprot_i[2:1];

  assign err_o = (off >= SPAN)
               | (off[BYTE_W-1:0] != '0)
               | (pwrite_i & RO_MASK[idx_o])
               | (pwrite_i & PRIV_WRITE & ~pprot_i[0]);
endmodule

// File: rtl/apb_reg_slave.sv
// APB4 completer for a bank of XLEN-wide registers with wait states and pslverr.
module apb_reg_slave
  import apb_reg_slave_pkg::*;
#(
  parameter int unsigned           REG_NUM     = 8,
  parameter logic [PADDR_SIZE-1:0] BASE_ADDR   = '0,
  parameter int unsigned           WAIT_CYCLES = 0,
  parameter logic [REG_NUM-1:0]    RO_MASK     = '0,
  parameter bit                    PRIV_WRITE  = 1'b1
)(
  input  logic                      clk,
  input  logic                      rst_n,
  ApbIO.slave                       apb,
  output logic [REG_NUM*XLEN-1:0]   reg_o,
  output logic [REG_NUM-1:0]        wr_o,
  input  logic [REG_NUM*XLEN-1:0]   ro_i
);
  localparam int unsigned IDX_W = $clog2(REG_NUM);
  localparam int unsigned NB    = XLEN/8;

  ApbSlvState                  state_q, state_d;
  logic [APB_WAIT_W-1:0]       cnt_q, cnt_d;
  logic [IDX_W-1:0]            idx;
  logic                        err, pready, we;
  logic [REG_NUM-1:0]          wr_d, wr_q;
  logic [REG_NUM-1:0][XLEN-1:0] reg_q;
  logic [XLEN-1:0]             rd_val;

  apb_slave_decode #(
    .REG_NUM(REG_NUM), .BASE_ADDR(BASE_ADDR), .RO_MASK(RO_MASK), .PRIV_WRITE(PRIV_WRITE)
  ) u_dec (
    .paddr_i(apb.paddr), .pwrite_i(apb.pwrite), .pprot_i(apb.pprot),
    .idx_o(idx), .err_o(err)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      APB_IDLE:
        if (apb.psel && !apb.penable) begin
          state_d = APB_ACCESS;
          cnt_d   = APB_WAIT_W'(WAIT_CYCLES);
        end
      APB_ACCESS:
        if (!apb.psel)         state_d = APB_IDLE;
        else if (cnt_q != '0)  cnt_d   = cnt_q - 1'b1;
        else if (apb.penable)  state_d = APB_IDLE;
      default: state_d = APB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= APB_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end

  assign pready = (state_q == APB_ACCESS) & (cnt_q == '0) & apb.psel & apb.penable;
  assign we     = pready & apb.pwrite & ~err;
  assign wr_d   = we ? (REG_NUM'(1) << idx) : '0;

  // Strobed byte merge; pstrb=0 still raises the wr_o pulse through wr_d.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      reg_q <= '0;
      wr_q  <= '0;
    end else begin
      wr_q <= wr_d;
      for (int i = 0; i < REG_NUM; i++)
        if (wr_d[i])
          for (int k = 0; k < NB; k++)
            if (apb.pstrb[k]) reg_q[i][k*8 +: 8] <= apb.pwdata[k*8 +: 8];
    end

  assign rd_val      = RO_MASK[idx] ? ro_i[idx*XLEN +: XLEN] : reg_q[idx];
  assign apb.pready  = pready;
  assign apb.pslverr = pready & err;
  assign apb.prdata  = (pready & ~err) ? rd_val : '0;
  assign reg_o       = reg_q;
  assign wr_o        = wr_q;
endmodule

// File: tb/tb_apb_reg_slave.sv
// Directed bench: vector table on a zero-wait instance, hand sequences on a 3-wait instance.
module tb_apb_reg_slave;
  import apb_reg_slave_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [31:0]  paddr;
  logic         psel, penable, pwrite, tgt;
  logic [63:0]  pwdata;
  logic [7:0]   pstrb;
  logic [2:0]   pprot;
  logic [511:0] ro, reg0, reg3;
  logic [7:0]   wr0, wr3;
  logic         pready, pslverr;
  logic [63:0]  prdata;

  ApbIO #(.ADDR_WIDTH(32), .DATA_WIDTH(64)) a0 ();
  ApbIO #(.ADDR_WIDTH(32), .DATA_WIDTH(64)) a3 ();

  assign a0.paddr = paddr;  assign a3.paddr = paddr;
  assign a0.pwrite = pwrite; assign a3.pwrite = pwrite;
  assign a0.pwdata = pwdata; assign a3.pwdata = pwdata;
  assign a0.pstrb = pstrb;  assign a3.pstrb = pstrb;
  assign a0.pprot = pprot;  assign a3.pprot = pprot;
  assign a0.penable = penable; assign a3.penable = penable;
  assign a0.psel = psel & ~tgt;
  assign a3.psel = psel & tgt;
  assign pready  = tgt ? a3.pready  : a0.pready;
  assign pslverr = tgt ? a3.pslverr : a0.pslverr;
  assign prdata  = tgt ? a3.prdata  : a0.prdata;

  apb_reg_slave #(.REG_NUM(8), .BASE_ADDR(32'h1000), .WAIT_CYCLES(0),
                  .RO_MASK(8'h80), .PRIV_WRITE(1'b1)) u0 (
    .clk(clk), .rst_n(rst_n), .apb(a0), .reg_o(reg0), .wr_o(wr0), .ro_i(ro));
  apb_reg_slave #(.REG_NUM(8), .BASE_ADDR(32'h1000), .WAIT_CYCLES(3),
                  .RO_MASK(8'h80), .PRIV_WRITE(1'b1)) u3 (
    .clk(clk), .rst_n(rst_n), .apb(a3), .reg_o(reg3), .wr_o(wr3), .ro_i(ro));

  typedef struct {
    logic [31:0] addr; logic w; logic [63:0] d; logic [7:0] s; logic [2:0] p;
    logic [63:0] rd; logic e; logic [7:0] wr;
  } vec_t;
  vec_t tv[15];

  int pass_cnt = 0;
  int tot_cnt  = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tot_cnt++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
    else pass_cnt++;
  endtask

  // Leaves the bus idle-free: the caller may start the next setup immediately.
  task automatic xfer(input logic [31:0] a, input logic w, input logic [63:0] d,
                      input logic [7:0] s, input logic [2:0] p,
                      output logic [63:0] rd, output logic e, output int cyc);
    paddr = a; pwrite = w; pwdata = d; pstrb = s; pprot = p;
    psel = 1'b1; penable = 1'b0;
    @(posedge clk); #1; penable = 1'b1; #1;
    cyc = 1;
    while (!pready && cyc < 40) begin
      @(posedge clk); #2;
      cyc++;
    end
    chk("pready_seen", 64'(pready), 64'd1);
    rd = prdata; e = pslverr;
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  logic [63:0] rd;
  logic        e, seen;
  int          cyc;

  initial begin
    tv[0]  = '{32'h1008, 1'b1, 64'hDEADBEEF_CAFEF00D, 8'hFF, 3'b001, 64'h0, 1'b0, 8'h02};
    tv[1]  = '{32'h1008, 1'b0, 64'h0, 8'hFF, 3'b001, 64'hDEADBEEF_CAFEF00D, 1'b0, 8'h00};
    tv[2]  = '{32'h1010, 1'b1, 64'hFFFFFFFF_FFFFFFFF, 8'hFF, 3'b001, 64'h0, 1'b0, 8'h04};
    tv[3]  = '{32'h1010, 1'b1, 64'h11223344_55667788, 8'h0F, 3'b001, 64'h0, 1'b0, 8'h04};
    tv[4]  = '{32'h1010, 1'b0, 64'h0, 8'h00, 3'b001, 64'hFFFFFFFF_55667788, 1'b0, 8'h00};
    tv[5]  = '{32'h1040, 1'b0, 64'h0, 8'hFF, 3'b001, 64'h0, 1'b1, 8'h00};
    tv[6]  = '{32'h1004, 1'b1, 64'h12345678_9ABCDEF0, 8'hFF, 3'b001, 64'h0, 1'b1, 8'h00};
    tv[7]  = '{32'h1038, 1'b1, 64'h12345678_9ABCDEF0, 8'hFF, 3'b001, 64'h0, 1'b1, 8'h00};
    tv[8]  = '{32'h1018, 1'b1, 64'h12345678_9ABCDEF0, 8'hFF, 3'b000, 64'h0, 1'b1, 8'h00};
    tv[9]  = '{32'h1018, 1'b0, 64'h0, 8'h00, 3'b001, 64'h0, 1'b0, 8'h00};
    tv[10] = '{32'h1038, 1'b0, 64'h0, 8'h00, 3'b001, 64'h5A5A, 1'b0, 8'h00};
    tv[11] = '{32'h1020, 1'b1, 64'hFFFFFFFF_FFFFFFFF, 8'h00, 3'b001, 64'h0, 1'b0, 8'h10};
    tv[12] = '{32'h1020, 1'b0, 64'h0, 8'h00, 3'b001, 64'h0, 1'b0, 8'h00};
    tv[13] = '{32'h0FF8, 1'b0, 64'h0, 8'h00, 3'b001, 64'h0, 1'b1, 8'h00};
    tv[14] = '{32'h1008, 1'b0, 64'h0, 8'h00, 3'b000, 64'hDEADBEEF_CAFEF00D, 1'b0, 8'h00};

    ro = '0;
    ro[7*64 +: 64] = 64'h5A5A;
    ro[1*64 +: 64] = 64'hBAD0BAD0_BAD0BAD0;
    ro[4*64 +: 64] = 64'h4444;
    paddr = '0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    pwdata = '0; pstrb = '0; pprot = '0; tgt = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_pready",  64'(a0.pready),  64'd0);
    chk("rst_pslverr", 64'(a0.pslverr), 64'd0);
    chk("rst_prdata",  a0.prdata,       64'd0);
    chk("rst_reg",     64'(|{reg0, reg3}), 64'd0);
    chk("rst_wr",      64'({wr0, wr3}), 64'd0);
    rst_n = 1'b1;
    idle(1);

    for (int i = 0; i < 15; i++) begin
      xfer(tv[i].addr, tv[i].w, tv[i].d, tv[i].s, tv[i].p, rd, e, cyc);
      chk($sformatf("v%0d_err", i), 64'(e), 64'(tv[i].e));
      chk($sformatf("v%0d_lat", i), 64'(cyc), 64'd1);
      chk($sformatf("v%0d_wr", i),  64'(wr0), 64'(tv[i].wr));
      if (!tv[i].w || tv[i].e) chk($sformatf("v%0d_rd", i), rd, tv[i].rd);
    end
    chk("reg1", reg0[1*64 +: 64], 64'hDEADBEEF_CAFEF00D);
    chk("reg2", reg0[2*64 +: 64], 64'hFFFFFFFF_55667788);
    chk("reg3", reg0[3*64 +: 64], 64'h0);
    chk("reg4", reg0[4*64 +: 64], 64'h0);
    chk("reg7", reg0[7*64 +: 64], 64'h0);

    // wr_o is a single-cycle pulse
    xfer(32'h1028, 1'b1, 64'h1234, 8'hFF, 3'b001, rd, e, cyc);
    chk("pulse_on", 64'(wr0), 64'h20);
    idle(1);
    chk("pulse_off", 64'(wr0), 64'h0);
    chk("reg5", reg0[5*64 +: 64], 64'h1234);

    // psel & penable straight from IDLE gets no response
    paddr = 32'h1008; pwrite = 1'b1; pwdata = 64'h0; pstrb = 8'hFF; pprot = 3'b001;
    psel = 1'b1; penable = 1'b1;
    seen = 1'b0;
    repeat (3) begin @(posedge clk); #1; seen = seen | pready | (|wr0); end
    chk("idle_enable_noresp", 64'(seen), 64'd0);
    psel = 1'b0; penable = 1'b0;
    idle(1);
    chk("idle_enable_reg1", reg0[1*64 +: 64], 64'hDEADBEEF_CAFEF00D);

    // Wait-state instance: back-to-back write then read
    tgt = 1'b1;
    xfer(32'h1008, 1'b1, 64'hA5A50000_11112222, 8'hFF, 3'b001, rd, e, cyc);
    chk("w3_lat", 64'(cyc), 64'd4);
    chk("w3_err", 64'(e), 64'd0);
    chk("w3_wr",  64'(wr3), 64'h02);
    xfer(32'h1008, 1'b0, 64'h0, 8'h00, 3'b001, rd, e, cyc);
    chk("r3_lat", 64'(cyc), 64'd4);
    chk("r3_rd",  rd, 64'hA5A50000_11112222);

    // Drop psel after one wait cycle
    paddr = 32'h1010; pwrite = 1'b1; pwdata = 64'h77; pstrb = 8'hFF; pprot = 3'b001;
    psel = 1'b1; penable = 1'b0;
    @(posedge clk); #1; penable = 1'b1;
    @(posedge clk); #1;
    chk("drop_wait", 64'(pready), 64'd0);
    psel = 1'b0; penable = 1'b0;
    seen = 1'b0;
    repeat (5) begin @(posedge clk); #1; seen = seen | pready | (|wr3); end
    chk("drop_noresp", 64'(seen), 64'd0);
    xfer(32'h1010, 1'b0, 64'h0, 8'h00, 3'b001, rd, e, cyc);
    chk("drop_rd",  rd, 64'h0);
    chk("drop_lat", 64'(cyc), 64'd4);

    // Reset during the wait phase of a write
    paddr = 32'h1018; pwrite = 1'b1; pwdata = 64'hFEED; pstrb = 8'hFF; pprot = 3'b001;
    psel = 1'b1; penable = 1'b0;
    @(posedge clk); #1; penable = 1'b1;
    @(posedge clk); #1; rst_n = 1'b0;
    #1;
    chk("mid_rst_pready", 64'(pready), 64'd0);
    chk("mid_rst_reg", 64'(|{reg0, reg3}), 64'd0);
    idle(2);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (6) begin @(posedge clk); #1; seen = seen | pready | (|wr3); end
    chk("post_rst_noresp", 64'(seen), 64'd0);
    chk("post_rst_reg", 64'(|reg3), 64'd0);
    psel = 1'b0; penable = 1'b0;
    idle(1);
    xfer(32'h1018, 1'b0, 64'h0, 8'h00, 3'b001, rd, e, cyc);
    chk("post_rst_rd",  rd, 64'h0);
    chk("post_rst_lat", 64'(cyc), 64'd4);

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end
endmodule
